load_store_unit: RTL and testbench

//   Memory stage of the RV32I core. Sits directly downstream of the ALU.
//   - Takes the ALU-computed effective address plus rs2 store data.
//   - Runs one load or store on a single-outstanding valid/ack data-memory bus.
//   - Aligns store bytes onto lanes; extracts and sign/zero-extends load data.
//   - Returns a one-cycle response to writeback.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store at a time over a single-outstanding valid/ack bus.
// Optional `LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into access faults.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam bit TIMEOUT_EN = (ACK_TIMEOUT != 0);
    // Last REQ cycle index before the request is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EN ? ACK_TIMEOUT - 1 : 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             op_we;
    logic [2:0]       op_funct3;
    logic [1:0]       op_lane;

    logic             op_legal;
    logic             op_fault;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             timeout_hit;

    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

    always_comb begin
        op_legal = 1'b0;
        if (req_we) begin
            op_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            op_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign op_fault   = !op_legal || misaligned;
`else
    // Misaligned low bits are simply dropped by the lane logic below.
    assign op_fault   = !op_legal;
`endif

    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (op_lane)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_we     <= 1'b0;
            op_funct3 <= 3'b000;
            op_lane   <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'b0000;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we     <= req_we;
                        op_funct3 <= req_funct3;
                        op_lane   <= req_addr[1:0];
                        cnt       <= '0;
                        if (op_fault) begin
                            state     <= RESP;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_we ? st_wdata : 32'd0;
                            mem_wstrb <= req_we ? st_wstrb : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the final allowed cycle still completes normally.
                    if (mem_ack || timeout_hit) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_wstrb <= 4'b0000;
                        rsp_err   <= !mem_ack;
                        rsp_rdata <= (mem_ack && !op_we) ? ld_data : 32'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_rsp_pulse: assert property (@(posedge clk) disable iff (rst) rsp_valid |=> !rsp_valid);
    a_req_state: assert property (@(posedge clk) disable iff (rst) mem_req |-> state == REQ);
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_req && !mem_ack && !timeout_hit) |=> (mem_req && $stable(mem_addr) &&
        $stable(mem_wdata) && $stable(mem_wstrb) && $stable(mem_we)));

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(
        .ACK_TIMEOUT (TO),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---- reference model: access size in bytes is 1 << funct3[1:0] ----
    function automatic bit op_faults(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size;
        bit legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        size = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        if ((addr % size) != 0) return 1'b1;
`else
        if (size == 0 && addr == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        if (f3[1:0] == 2'd0) return (wdata & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        if (f3[1:0] == 2'd0) return 32'd1 << (addr % 4);
        if (f3[1:0] == 2'd1) return ((addr / 2) % 2 != 0) ? 32'hC : 32'h3;
        return 32'hF;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned size;
        int unsigned off;
        logic [31:0] v;
        size = 1 << f3[1:0];
        off  = ((addr % 4) / size) * size;
        v    = rdata >> (8 * off);
        if (size < 4) begin
            v = v & ((32'd1 << (8 * size)) - 32'd1);
            if (!f3[2] && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
        end
        return v;
    endfunction

    // ack_delay = REQ cycles before ack; >= TO means the ack is withheld.
    task automatic do_op(input string tag, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_delay);
        bit fault;
        bit timeout;
        fault   = op_faults(we, f3, addr);
        timeout = !fault && (ack_delay >= int'(TO));
        check_eq({tag, ".ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (!fault) begin
            for (int i = 0; i < int'(TO); i++) begin
                check_eq({tag, ".mem_req"}, mem_req, 1);
                check_eq({tag, ".mem_we"}, mem_we, we);
                check_eq({tag, ".mem_addr"}, mem_addr, addr & ~32'd3);
                check_eq({tag, ".mem_wstrb"}, mem_wstrb, we ? exp_wstrb(f3, addr) : 32'd0);
                if (we) check_eq({tag, ".mem_wdata"}, mem_wdata, exp_wdata(f3, wdata));
                check_eq({tag, ".rsp_early"}, rsp_valid, 0);
                if (i == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_rdata = $urandom;
                end
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                if (i == ack_delay) break;
            end
        end
        check_eq({tag, ".rsp_valid"}, rsp_valid, 1);
        check_eq({tag, ".mem_req_off"}, mem_req, 0);
        check_eq({tag, ".rsp_err"}, rsp_err, fault || timeout);
        check_eq({tag, ".rsp_rdata"}, rsp_rdata,
                 (fault || timeout || we) ? 32'd0 : exp_load(f3, addr, rdata));
        @(posedge clk);
        #1;
        check_eq({tag, ".rsp_drop"}, rsp_valid, 0);
        check_eq({tag, ".ready_back"}, req_ready, 1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        #1;
        check_eq("reset.ready", req_ready, 1);
        check_eq("reset.mem_req", mem_req, 0);
        check_eq("reset.mem_wstrb", mem_wstrb, 0);
        check_eq("reset.mem_addr", mem_addr, 0);
        check_eq("reset.rsp_valid", rsp_valid, 0);
        check_eq("reset.rsp_err", rsp_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op("lw_basic", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        do_op("lb_sign", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
        do_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1);
        do_op("lh_sign", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 0);
        do_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 2);
        do_op("sb_lane1", 1'b1, 3'b000, 32'h201, 32'h1234_56AB, 32'h0, 0);
        do_op("sh_hi", 1'b1, 3'b001, 32'h202, 32'hCAFE_F00D, 32'h0, 1);
        do_op("sw", 1'b1, 3'b010, 32'h204, 32'hA5A5_5A5A, 32'h0, 0);
        do_op("timeout", 1'b0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 99);
        do_op("ack_at_limit", 1'b0, 3'b010, 32'h304, 32'h0, 32'h3333_4444, int'(TO) - 1);
        do_op("lw_misalign", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0BAD_F00D, 0);
        do_op("ld_illegal", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        do_op("st_illegal", 1'b1, 3'b100, 32'h100, 32'h1, 32'h0, 0);

        // Acks outside REQ must be ignored.
        mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("stray_ack.rsp", rsp_valid, 0);
            check_eq("stray_ack.ready", req_ready, 1);
        end
        mem_ack = 1'b0;

        // Reset in the middle of REQ, then a late ack.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h400;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("rst_mid.mem_req_on", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid.mem_req_off", mem_req, 0);
        check_eq("rst_mid.ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            check_eq("rst_mid.no_rsp", rsp_valid, 0);
            check_eq("rst_mid.no_req", mem_req, 0);
        end

        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3;
            bit we;
            we = 1'($urandom);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
                 (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            if (!we && f3 == 3'd3) f3 = 3'd4;
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'($urandom);
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                check_eq("rand.idle_rsp", rsp_valid, 0);
            end
            do_op("rand", we, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
